pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the WISC five-stage core, replacing the fixed-field per-stage latches (F/D, D/X, X/M, M/W) with one generic block. It carries a packed data bus, a packed control bus, the instruction word and a halt/dump flag, plus a valid bit. It adds stall (hold) and flush (bubble insertion) that a plain latch bank lacks. An optional performance counter pair records stalled and squashed cycles per stage.

---
 rtl/pipe_stage_reg_pkg.sv | 17 +
 rtl/pipe_en_reg.sv | 17 +
 rtl/pipe_stage_reg.sv | 60 ++++++
 tb/tb_pipe_stage_reg.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared encodings and widths for the generic pipeline stage register.
package pipe_stage_reg_pkg;
    localparam logic [15:0] PIPE_NOP = 16'h0800;
    localparam int PIPE_CTRL_W = 8;
    localparam int CNT_W = 16;
    localparam int CTRL_REGWRT = 0;
    localparam int CTRL_MEMWRT = 1;
    localparam int CTRL_READEN = 2;
    localparam int CTRL_WBSEL_LO = 3;
    localparam int CTRL_WBSEL_HI = 4;
    localparam int CTRL_WRTREG_LO = 5;
    localparam int CTRL_WRTREG_HI = 7;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && !(&c)) ? c + 1'b1 : c;
    endfunction
endpackage

// File: rtl/pipe_en_reg.sv
// pipe_en_reg: width-parametrised register with load enable and async active-high reset.
module pipe_en_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int W = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= RST_VAL;
        else if (en) q <= d;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage register with stall/flush; PIPE_PERF_CNT_EN adds
// saturating stall/flush counters (tied to zero when undefined).
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int INSTR_W = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(PIPE_NOP)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               validIn,
    input  logic [DATA_W-1:0]  dataIn,
    input  logic [CTRL_W-1:0]  ctrlIn,
    input  logic [INSTR_W-1:0] instrIn,
    input  logic               haltIn,
    output logic               validOut,
    output logic [DATA_W-1:0]  dataOut,
    output logic [CTRL_W-1:0]  ctrlOut,
    output logic [INSTR_W-1:0] instrOut,
    output logic               haltOut,
    output logic [CNT_W-1:0]   stallCnt,
    output logic [CNT_W-1:0]   flushCnt
);
    logic upd, bub;
    assign upd = flush | ~stall;
    // bubble fields are forced so an invalid slot can never cause side effects
    assign bub = flush | ~validIn;

    pipe_en_reg #(.W(1)) u_valid (
        .clk(clk), .rst(rst), .en(upd), .d(~flush & validIn), .q(validOut));
    pipe_en_reg #(.W(DATA_W)) u_data (
        .clk(clk), .rst(rst), .en(~flush & ~stall), .d(dataIn), .q(dataOut));
    pipe_en_reg #(.W(CTRL_W)) u_ctrl (
        .clk(clk), .rst(rst), .en(upd), .d(bub ? '0 : ctrlIn), .q(ctrlOut));
    pipe_en_reg #(.W(INSTR_W), .RST_VAL(NOP_INSTR)) u_instr (
        .clk(clk), .rst(rst), .en(upd), .d(bub ? NOP_INSTR : instrIn), .q(instrOut));
    pipe_en_reg #(.W(1)) u_halt (
        .clk(clk), .rst(rst), .en(upd), .d(~bub & haltIn), .q(haltOut));

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= sat_inc(stall_q, stall & ~flush & validOut);
            flush_q <= sat_inc(flush_q, flush & validOut);
        end
    assign stallCnt = stall_q;
    assign flushCnt = flush_q;
`else
    assign stallCnt = '0;
    assign flushCnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of reset, load, stall, flush, bubble and counters.
module tb_pipe_stage_reg;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic clk = 1'b0, rst, stall, flush, validIn, haltIn;
    logic [63:0] dataIn;
    logic [7:0] ctrlIn;
    logic [15:0] instrIn;
    logic validOut, haltOut;
    logic [63:0] dataOut;
    logic [7:0] ctrlOut;
    logic [15:0] instrOut, stallCnt, flushCnt;
    int total = 0, bad = 0;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .validIn(validIn),
        .dataIn(dataIn), .ctrlIn(ctrlIn), .instrIn(instrIn), .haltIn(haltIn),
        .validOut(validOut), .dataOut(dataOut), .ctrlOut(ctrlOut), .instrOut(instrOut),
        .haltOut(haltOut), .stallCnt(stallCnt), .flushCnt(flushCnt));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in();
        dataIn = {$urandom, $urandom};
        ctrlIn = 8'($urandom);
        instrIn = 16'($urandom);
        haltIn = 1'($urandom);
        validIn = 1'($urandom);
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 64'(validOut), 64'd0);
        chk({tag, "_ctrl"}, 64'(ctrlOut), 64'd0);
        chk({tag, "_instr"}, 64'(instrOut), 64'h0800);
        chk({tag, "_halt"}, 64'(haltOut), 64'd0);
    endtask

    task automatic chk_cnt(input string tag, input int s, input int f);
        chk({tag, "_scnt"}, 64'(stallCnt), PERF ? 64'(s) : 64'd0);
        chk({tag, "_fcnt"}, 64'(flushCnt), PERF ? 64'(f) : 64'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b1; flush = 1'b0;
        rand_in();
        validIn = 1'b1;
        #2;
        chk_bubble("rst0");
        chk("rst0_data", dataOut, 64'd0);
        chk_cnt("rst0", 0, 0);
        stall = 1'b0;
        tick();
        chk_bubble("rsthold");
        rst = 1'b0;
        // load
        validIn = 1'b1; dataIn = 64'h1234_5678_9ABC_DEF0; ctrlIn = 8'hA5;
        instrIn = 16'hC123; haltIn = 1'b0;
        tick();
        chk("ld_valid", 64'(validOut), 64'd1);
        chk("ld_data", dataOut, 64'h1234_5678_9ABC_DEF0);
        chk("ld_ctrl", 64'(ctrlOut), 64'hA5);
        chk("ld_instr", 64'(instrOut), 64'hC123);
        chk("ld_halt", 64'(haltOut), 64'd0);
        // stall three cycles with changing inputs
        stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            rand_in();
            tick();
            chk("st_valid", 64'(validOut), 64'd1);
            chk("st_data", dataOut, 64'h1234_5678_9ABC_DEF0);
            chk("st_ctrl", 64'(ctrlOut), 64'hA5);
            chk("st_instr", 64'(instrOut), 64'hC123);
            chk_cnt("st", i, 0);
        end
        // flush beats stall
        flush = 1'b1;
        tick();
        chk_bubble("fl");
        chk_cnt("fl", 3, 1);
        // flushing an empty slot is not counted
        tick();
        chk_cnt("fl2", 3, 1);
        // bubble in with live-looking fields
        flush = 1'b0; stall = 1'b0;
        validIn = 1'b0; ctrlIn = 8'hFF; haltIn = 1'b1; instrIn = 16'h1234;
        dataIn = 64'hDEAD_BEEF_0000_0001;
        tick();
        chk_bubble("bub");
        chk("bub_data", dataOut, 64'hDEAD_BEEF_0000_0001);
        // stalling a bubble is not counted
        stall = 1'b1;
        tick();
        tick();
        chk_bubble("bubst");
        chk_cnt("bubst", 3, 1);
        // load with halt
        stall = 1'b0; validIn = 1'b1; haltIn = 1'b1; ctrlIn = 8'h3C;
        instrIn = 16'h6001; dataIn = 64'h0F0F_0F0F_0F0F_0F0F;
        tick();
        chk("hl_valid", 64'(validOut), 64'd1);
        chk("hl_halt", 64'(haltOut), 64'd1);
        chk("hl_ctrl", 64'(ctrlOut), 64'h3C);
        chk("hl_instr", 64'(instrOut), 64'h6001);
        // async reset mid-stall
        stall = 1'b1;
        tick();
        chk_cnt("pre_ar", 4, 1);
        #2 rst = 1'b1;
        #1;
        chk_bubble("ar");
        chk("ar_data", dataOut, 64'd0);
        chk_cnt("ar", 0, 0);
        #1 rst = 1'b0;
        stall = 1'b0; validIn = 1'b1; haltIn = 1'b0; ctrlIn = 8'h81;
        instrIn = 16'hA00A; dataIn = 64'h0000_0000_CAFE_F00D;
        tick();
        chk("ar_ld_valid", 64'(validOut), 64'd1);
        chk("ar_ld_data", dataOut, 64'h0000_0000_CAFE_F00D);
        chk("ar_ld_ctrl", 64'(ctrlOut), 64'h81);
        chk("ar_ld_instr", 64'(instrOut), 64'hA00A);
        // long stall on valid content
        stall = 1'b1;
        repeat (65540) tick();
        chk("sat_scnt", 64'(stallCnt), PERF ? 64'hFFFF : 64'd0);
        chk("sat_fcnt", 64'(flushCnt), 64'd0);
        chk("sat_ctrl", 64'(ctrlOut), 64'h81);
        flush = 1'b1;
        tick();
        chk_cnt("sat_fl", 16'hFFFF, 1);
        chk_bubble("sat_fl");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
